// File: rtl/main_mem_responder_if.sv
// Handshake bundle between the L1 cache (master) and main_mem_responder (slave).
// dataBus is bidirectional and is carried as a separate inout port of the responder.
interface main_mem_responder_if;
    logic        request;
    logic        MEM_WE;
    logic [31:0] addressBus;
    logic        MEM_ACK;
    logic        proto_err;
    logic [31:0] read_count;
    logic [31:0] write_count;

    modport master (
        output request, MEM_WE, addressBus,
        input  MEM_ACK, proto_err, read_count, write_count
    );

    modport slave (
        input  request, MEM_WE, addressBus,
        output MEM_ACK, proto_err, read_count, write_count
    );
endinterface

// File: rtl/main_mem_responder.sv
// Clocked main-memory responder: slave end of the four-phase request/ACK handshake.
// Optional feature macro: MAIN_MEM_RESP_STATS_EN (access counters and commit trace).
module main_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    main_mem_responder_if.slave     bus,
    inout  wire  [31:0]             dataBus
);
    localparam int unsigned Words   = 1 << DEPTH_LOG2;
    localparam logic [7:0]  LatLoad = 8'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_next;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_ack;
    logic                  r_perr;
    logic [31:0]           r_mem [Words];
    logic [Words-1:0]      r_valid;

    logic                  w_capture;
    logic                  w_commit;
    logic                  w_abort;
    logic [31:0]           w_rd_word;
    logic                  w_unused_addr;

    // Only the word-index bits of the byte address matter; the rest alias.
    assign w_unused_addr = ^{bus.addressBus[31:DEPTH_LOG2+2], bus.addressBus[1:0]};
    assign w_rd_word     = r_valid[r_idx] ? r_mem[r_idx] : 32'h0000_0000;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        w_abort      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.request) begin
                    w_capture    = 1'b1;
                    w_cnt_next   = LatLoad;
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (!bus.request) begin
                    w_abort      = 1'b1;
                    w_state_next = StIdle;
                end else if (r_cnt == 8'd0) begin
                    w_commit     = 1'b1;
                    w_state_next = StAck;
                end else begin
                    w_cnt_next   = r_cnt - 8'd1;
                end
            end
            StAck: begin
                if (!bus.request) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        // A reset edge wins over any commit that would otherwise happen on it.
        if (reset) begin
            w_capture = 1'b0;
            w_commit  = 1'b0;
            w_abort   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_ack   <= 1'b0;
            r_perr  <= 1'b0;
            r_valid <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= (w_state_next == StAck);
            r_perr  <= w_abort;
            if (w_commit && r_we) r_valid[r_idx] <= 1'b1;
        end
    end

    // Holding registers and storage carry no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_idx   <= bus.addressBus[DEPTH_LOG2+1:2];
            r_we    <= bus.MEM_WE;
            r_wdata <= dataBus;
        end
        if (w_commit) begin
            if (r_we) r_mem[r_idx] <= r_wdata;
            else      r_rdata      <= w_rd_word;
        end
    end

    assign bus.MEM_ACK   = r_ack;
    assign bus.proto_err = r_perr;
    assign dataBus       = (r_state == StAck && !r_we) ? r_rdata : 32'hzzzz_zzzz;

`ifdef MAIN_MEM_RESP_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= 32'd0;
            r_wr_cnt <= 32'd0;
        end else if (w_commit) begin
            if (r_we) r_wr_cnt <= r_wr_cnt + 32'd1;
            else      r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            $display("main_mem: %s word=%0h data=%h", r_we ? "WR" : "RD", r_idx,
                     r_we ? r_wdata : w_rd_word);
        end
    end

    assign bus.read_count  = r_rd_cnt;
    assign bus.write_count = r_wr_cnt;
`else
    assign bus.read_count  = 32'h0;
    assign bus.write_count = 32'h0;
`endif

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

- Synthesizable, clocked main-memory responder: the slave end of the L1-cache-to-memory four-phase request/acknowledge handshake.
- Receives `request`, `MEM_WE` and `addressBus` from the L1 cache, waits a programmable access latency, then either commits a write or returns read data on the shared bidirectional `dataBus` with `MEM_ACK`.
- Sits below the L1 cache and is the cycle-accurate replacement for the behavioural memory model in the paging-system bench.

## Interface
- `DEPTH_LOG2`, 10, log2 of storage depth in 32-bit words (default 1024 words).
- `LATENCY`, 4, clock edges from request sample to commit/ACK; legal range 1..255.
- `clk`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `addressBus`  input  32  byte address; word index = `addressBus[DEPTH_LOG2+1:2]`.
- `dataBus`  inout  32  write data from cache / read data to cache.
- `request`  input  1  access request from cache; held high until ACK seen.
- `MEM_WE`  input  1  1 = write, 0 = read; sampled with `request`.
- `MEM_ACK`  output  1  access complete; read data valid while high.
- `proto_err`  output  1  one-cycle pulse on handshake violation.
- `read_count`  output  32  completed reads since reset.
- `write_count`  output  32  completed writes since reset.

## Operation
- Storage: `2**DEPTH_LOG2` words plus one valid bit per word.
  - Reset clears all valid bits; contents are not cleared.
  - A read of a word with valid=0 returns 32'h0000_0000.
- Address handling:
  - `addressBus[1:0]` ignored.
  - Bits above `DEPTH_LOG2+1` ignored (aliasing, no error).
- State machine (registered state, registered outputs):
  - IDLE: `MEM_ACK`=0, bus released.
    - On `request`=1: capture index, `MEM_WE` and (if write) `dataBus` into holding registers.
    - Load counter with `LATENCY-1`; go WAIT.
  - WAIT: if `request`=0, raise `proto_err`, go IDLE with no commit and no count.
    - Otherwise, if counter=0: commit (write: store word, set valid; read: latch word or 0 into read register), increment the matching count, go ACK.
    - Otherwise decrement counter.
  - ACK: `MEM_ACK`=1.
    - While `request`=1, stay in ACK.
    - On `request`=0, go IDLE (`MEM_ACK` low on the next cycle).
- Bus drive: `dataBus` = read register only when state=ACK and captured op=read; high-Z otherwise.
- Address, `MEM_WE` and data changes after capture are ignored until the next IDLE.
- Counters wrap at 2^32.

## Timing
- Reset values: `MEM_ACK`=0, `proto_err`=0, `read_count`=0, `write_count`=0, `dataBus` high-Z, state=IDLE.
- Request sampled high at edge N → commit and `MEM_ACK`=1 after edge N+LATENCY.
- `MEM_ACK` holds until the first edge at which `request`=0 is sampled; it is low after that edge.
- Minimum turnaround: new `request` accepted at the edge after `MEM_ACK` falls, since IDLE requires one cycle with ACK low.
- `request` still high when IDLE is re-entered (cache did not drop it): treated as a new access. The cache must deassert before re-requesting.
- `proto_err`: high for exactly one cycle, the cycle after the aborting edge.
- Reset mid-operation: a write pending in WAIT is not committed. A read in ACK releases the bus and ACK after the reset edge.
- `LATENCY`=1: commit at the first edge after capture.

## Configuration
- `MAIN_MEM_RESP_STATS_EN` defined:
  - `read_count`/`write_count` registers are present and increment as above.
  - A `$display` of op, address and data is emitted at each commit (simulation only).
- Not defined: both count outputs are tied to 32'h0 and no display is emitted. Handshake behaviour is identical either way.

## Test plan
- Reset, then read 32'h0000_0040 with LATENCY=4 → `MEM_ACK` rises 4 edges after request sample; `dataBus`=32'h0000_0000; `read_count`=1.
- Write 32'hDEADBEEF to 32'h0000_0100, complete handshake, then read 32'h0000_0102 → returns 32'hDEADBEEF (low bits ignored); `write_count`=1, `read_count`=1.
- Write 32'h12345678 to 32'h0000_1004 with DEPTH_LOG2=10, read 32'h0000_0004 → 32'h12345678 (aliasing).
- Drop `request` 2 cycles into a write of 32'hCAFEF00D to 32'h0000_0020 → `proto_err` pulses 1 cycle, no ACK; subsequent read of 32'h0000_0020 returns 32'h0.
- Hold `request` high 5 cycles after ACK → `MEM_ACK` stays 1 and read data stays driven throughout; ACK falls one edge after `request` falls; bus is high-Z at the same time.
- Assert `reset` during WAIT of a write to 32'h0000_0080 → outputs reach reset values after that edge; later read of 32'h0000_0080 returns 32'h0; counts are 0.
